// File: rtl/cpu_pkg.sv
// Shared definitions for the operand-forwarding controller.
//   - forwarding mux select encodings
//   - controller FSM state encoding
//   - default widths of the shadow-slot destination field and stall counter
package cpu_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int CNT_W_DEF  = 16;

    // Shadow slot = {valid, rd, regwrite, memread}
    localparam int SLOT_FLAG_W = 3;

    localparam logic [1:0] FWD_SEL_REG   = 2'b00;
    localparam logic [1:0] FWD_SEL_EXMEM = 2'b01;
    localparam logic [1:0] FWD_SEL_MEMWB = 2'b10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

endpackage

// File: rtl/fwd_src_match.sv
// Per-operand forwarding comparator (combinational).
// Ports:
//   src, used             source register of the ID instruction and its read flag
//   ex_valid/regwrite/rd  instruction currently in EX (will sit in EX/MEM next cycle)
//   mem_valid/regwrite/rd instruction currently in MEM (will sit in MEM/WB next cycle)
//   sel                   mux select the operand needs once it reaches EX
module fwd_src_match
    import cpu_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src,
    input  logic              used,
    input  logic              ex_valid,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_valid,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    output logic [1:0]        sel
);

    // $0 is hard-wired, so it is never a forwarding source. The EX match is
    // checked first so the newest producer wins.
    always_comb begin
        sel = FWD_SEL_REG;
        if (used && (src != '0)) begin
            if (ex_valid && ex_regwrite && (src == ex_rd)) begin
                sel = FWD_SEL_EXMEM;
            end else if (mem_valid && mem_regwrite && (src == mem_rd)) begin
                sel = FWD_SEL_MEMWB;
            end
        end
    end

endmodule

// File: rtl/operand_fwd_ctrl.sv
// ALU operand forwarding and load-use stall controller for the MIPS pipeline.
// Tracks a shadow copy of destination info for EX, MEM and WB, registers the
// A/B bypass selects as the ID instruction moves into EX, and requests a
// single-cycle stall on a load-use hazard.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   id_*                   decoded fields of the instruction in ID
//   flush_i                branch/jump kill of the ID instruction
//   fwd_a_sel_o/fwd_b_sel_o operand mux selects for the instruction in EX
//   stall_o                hold PC and IF/ID, bubble into ID/EX
//   stall_cnt_o            saturating count of load-use stalls
//
// state    | meaning
// ST_RUN   | normal issue; stall on load-use hazard unless flushed
// ST_STALL | bubble just entered EX; ID instruction issues this cycle
module operand_fwd_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_rs_used_i,
    input  logic              id_rt_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    state_t state_q, state_d;

    logic              ex_valid_q, ex_regwrite_q, ex_memread_q;
    logic [REG_AW-1:0] ex_rd_q;
    logic              mem_valid_q, mem_regwrite_q, mem_memread_q;
    logic [REG_AW-1:0] mem_rd_q;
    // WB slot is kept only for debug visibility; write-through in the
    // register file already covers WB->ID.
    logic              wb_valid_q, wb_regwrite_q, wb_memread_q;
    logic [REG_AW-1:0] wb_rd_q;

    logic       hazard;
    logic       ex_load;
    logic [1:0] sel_a, sel_b;

    assign hazard = id_valid_i && ex_valid_q && ex_memread_q && (ex_rd_q != '0) &&
                    ((id_rs_used_i && (id_rs_i == ex_rd_q)) ||
                     (id_rt_used_i && (id_rt_i == ex_rd_q)));

    // Flush beats the hazard: the instruction is dying anyway.
    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hazard && !flush_i && !rst_i) begin
                    stall_o = 1'b1;
                    state_d = ST_STALL;
                end
            end
            ST_STALL: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    assign ex_load = id_valid_i && !stall_o && !flush_i;

    fwd_src_match #(.REG_AW(REG_AW)) u_match_a (
        .src          (id_rs_i),
        .used         (id_rs_used_i),
        .ex_valid     (ex_valid_q),
        .ex_regwrite  (ex_regwrite_q),
        .ex_rd        (ex_rd_q),
        .mem_valid    (mem_valid_q),
        .mem_regwrite (mem_regwrite_q),
        .mem_rd       (mem_rd_q),
        .sel          (sel_a)
    );

    fwd_src_match #(.REG_AW(REG_AW)) u_match_b (
        .src          (id_rt_i),
        .used         (id_rt_used_i),
        .ex_valid     (ex_valid_q),
        .ex_regwrite  (ex_regwrite_q),
        .ex_rd        (ex_rd_q),
        .mem_valid    (mem_valid_q),
        .mem_regwrite (mem_regwrite_q),
        .mem_rd       (mem_rd_q),
        .sel          (sel_b)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_RUN;
            ex_valid_q     <= 1'b0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            ex_rd_q        <= '0;
            mem_valid_q    <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_memread_q  <= 1'b0;
            mem_rd_q       <= '0;
            wb_valid_q     <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_memread_q   <= 1'b0;
            wb_rd_q        <= '0;
            fwd_a_sel_o    <= FWD_SEL_REG;
            fwd_b_sel_o    <= FWD_SEL_REG;
            stall_cnt_o    <= '0;
        end else begin
            state_q        <= state_d;
            wb_valid_q     <= mem_valid_q;
            wb_regwrite_q  <= mem_regwrite_q;
            wb_memread_q   <= mem_memread_q;
            wb_rd_q        <= mem_rd_q;
            mem_valid_q    <= ex_valid_q;
            mem_regwrite_q <= ex_regwrite_q;
            mem_memread_q  <= ex_memread_q;
            mem_rd_q       <= ex_rd_q;
            ex_valid_q     <= ex_load;
            ex_regwrite_q  <= ex_load && id_regwrite_i;
            ex_memread_q   <= ex_load && id_memread_i;
            ex_rd_q        <= ex_load ? id_rd_i : '0;
            fwd_a_sel_o    <= ex_load ? sel_a : FWD_SEL_REG;
            fwd_b_sel_o    <= ex_load ? sel_b : FWD_SEL_REG;
            if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
                stall_cnt_o <= stall_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
module tb_operand_fwd_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_rs_used, id_rt_used, id_regwrite, id_memread, flush;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          stall;
    logic [CW-1:0] stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    operand_fwd_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_valid_i    (id_valid),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_rs_used_i  (id_rs_used),
        .id_rt_used_i  (id_rt_used),
        .id_rd_i       (id_rd),
        .id_regwrite_i (id_regwrite),
        .id_memread_i  (id_memread),
        .flush_i       (flush),
        .fwd_a_sel_o   (fwd_a_sel),
        .fwd_b_sel_o   (fwd_b_sel),
        .stall_o       (stall),
        .stall_cnt_o   (stall_cnt)
    );

    // Reference model: history of what entered EX each cycle (bubbles included).
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       rw;
        bit       mr;
    } ent_t;

    ent_t          hist[$];
    logic [1:0]    exp_a, exp_b;
    logic [CW-1:0] exp_cnt;
    bit            prev_stall;

    function automatic ent_t bubble();
        ent_t e;
        e.v = 0; e.rd = 0; e.rw = 0; e.mr = 0;
        return e;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(bubble());
        exp_a = 0; exp_b = 0; exp_cnt = 0; prev_stall = 0;
    endtask

    // Producer one slot ahead -> EX/MEM bypass; two ahead -> MEM/WB bypass.
    function automatic logic [1:0] ref_sel(logic [4:0] src, logic used);
        int n = hist.size();
        if (!used || src == 0) return 2'd0;
        if (hist[n-1].v && hist[n-1].rw && hist[n-1].rd == src) return 2'd1;
        if (hist[n-2].v && hist[n-2].rw && hist[n-2].rd == src) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit ref_stall();
        ent_t p;
        if (rst || !id_valid || flush || prev_stall) return 0;
        p = hist[hist.size()-1];
        return p.v && p.mr && p.rd != 0 &&
               ((id_rs_used && id_rs == p.rd) || (id_rt_used && id_rt == p.rd));
    endfunction

    task automatic drive(bit v, int rs, bit rsu, int rt, bit rtu, int rd, bit rw, bit mr, bit fl);
        id_valid = v; id_rs = AW'(rs); id_rs_used = rsu; id_rt = AW'(rt); id_rt_used = rtu;
        id_rd = AW'(rd); id_regwrite = rw; id_memread = mr; flush = fl;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance one clock; model follows the edge, outputs settle before return.
    task automatic tick();
        bit s, entered;
        logic [1:0] a, b;
        ent_t e;
        s = ref_stall();
        a = ref_sel(id_rs, id_rs_used);
        b = ref_sel(id_rt, id_rt_used);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            entered = id_valid && !s && !flush;
            exp_a = entered ? a : 2'd0;
            exp_b = entered ? b : 2'd0;
            if (s && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
            prev_stall = s;
            e = bubble();
            if (entered) begin
                e.v = 1; e.rd = id_rd; e.rw = id_regwrite; e.mr = id_memread;
            end
            hist.push_back(e);
            if (hist.size() > 3) void'(hist.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1; nop();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        reset_dut(); #1;
        n_cmp++; if (fwd_a_sel !== 2'd0) begin n_fail++; $display("FAIL reset_a: got %0d want 0", fwd_a_sel); end
        n_cmp++; if (fwd_b_sel !== 2'd0) begin n_fail++; $display("FAIL reset_b: got %0d want 0", fwd_b_sel); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall); end
        n_cmp++; if (stall_cnt !== 0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_exmem_fwd();
        reset_dut();
        drive(1, 1, 1, 2, 1, 3, 1, 0, 0); tick();        // add $3,$1,$2
        drive(1, 3, 1, 5, 1, 4, 1, 0, 0); #1;            // sub $4,$3,$5
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL exmem_stall: got %0b want 0", stall); end
        tick(); #1;
        n_cmp++; if (fwd_a_sel !== 2'b01) begin n_fail++; $display("FAIL exmem_a: got %0d want 1", fwd_a_sel); end
        n_cmp++; if (fwd_b_sel !== 2'b00) begin n_fail++; $display("FAIL exmem_b: got %0d want 0", fwd_b_sel); end
    endtask

    task automatic test_memwb_fwd();
        reset_dut();
        drive(1, 1, 1, 2, 1, 3, 1, 0, 0); tick();        // add $3
        nop(); tick();
        drive(1, 7, 1, 3, 1, 6, 1, 0, 0); tick(); #1;    // or $6,$7,$3
        n_cmp++; if (fwd_b_sel !== 2'b10) begin n_fail++; $display("FAIL memwb_b: got %0d want 2", fwd_b_sel); end
        n_cmp++; if (fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL memwb_a: got %0d want 0", fwd_a_sel); end
        drive(1, 1, 1, 2, 1, 3, 1, 0, 0); tick();        // add $3
        drive(1, 4, 1, 5, 1, 3, 1, 0, 0); tick();        // add $3 again
        drive(1, 7, 1, 3, 1, 6, 1, 0, 0); tick(); #1;    // or $6,$7,$3
        n_cmp++; if (fwd_b_sel !== 2'b01) begin n_fail++; $display("FAIL newest_b: got %0d want 1", fwd_b_sel); end
    endtask

    task automatic test_load_use();
        reset_dut();
        drive(1, 9, 1, 8, 0, 8, 1, 1, 0); tick();        // lw $8,0($9)
        drive(1, 8, 1, 8, 1, 10, 1, 0, 0); #1;           // add $10,$8,$8
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %0b want 1", stall); end
        n_cmp++; if (stall_cnt !== 0) begin n_fail++; $display("FAIL lu_cnt0: got %0d want 0", stall_cnt); end
        tick(); #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_once: got %0b want 0", stall); end
        n_cmp++; if (stall_cnt !== 1) begin n_fail++; $display("FAIL lu_cnt1: got %0d want 1", stall_cnt); end
        n_cmp++; if (fwd_a_sel !== 2'b00) begin n_fail++; $display("FAIL lu_bubble_a: got %0d want 0", fwd_a_sel); end
        tick(); #1;
        n_cmp++; if (fwd_a_sel !== 2'b10) begin n_fail++; $display("FAIL lu_a: got %0d want 2", fwd_a_sel); end
        n_cmp++; if (fwd_b_sel !== 2'b10) begin n_fail++; $display("FAIL lu_b: got %0d want 2", fwd_b_sel); end
    endtask

    task automatic test_zero_reg();
        reset_dut();
        drive(1, 1, 1, 2, 1, 0, 1, 0, 0); tick();        // add $0,$1,$2
        drive(1, 0, 1, 0, 1, 4, 1, 0, 0); #1;            // reads $0
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall: got %0b want 0", stall); end
        tick(); #1;
        n_cmp++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            n_fail++; $display("FAIL zero_sel: got a=%0d b=%0d want 0/0", fwd_a_sel, fwd_b_sel); end
        drive(1, 9, 1, 0, 0, 0, 1, 1, 0); tick();        // lw $0
        drive(1, 0, 1, 0, 1, 5, 1, 0, 0); #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_load_stall: got %0b want 0", stall); end
        tick();
    endtask

    task automatic test_flush_hazard();
        reset_dut();
        drive(1, 9, 1, 8, 0, 8, 1, 1, 0); tick();        // lw $8
        drive(1, 8, 1, 8, 1, 10, 1, 0, 1); #1;           // add $10,$8,$8 flushed
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %0b want 0", stall); end
        tick(); #1;
        n_cmp++; if (stall_cnt !== 0) begin n_fail++; $display("FAIL flush_cnt: got %0d want 0", stall_cnt); end
        n_cmp++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            n_fail++; $display("FAIL flush_sel: got a=%0d b=%0d want 0/0", fwd_a_sel, fwd_b_sel); end
        drive(1, 8, 1, 2, 1, 11, 1, 0, 0); tick(); #1;   // lw now in MEM
        n_cmp++; if (fwd_a_sel !== 2'b10) begin n_fail++; $display("FAIL flush_after_a: got %0d want 2", fwd_a_sel); end
    endtask

    task automatic test_reset_mid_stall();
        reset_dut();
        drive(1, 9, 1, 8, 0, 8, 1, 1, 0); tick();
        drive(1, 8, 1, 8, 1, 10, 1, 0, 0); tick();       // now in STALL, cnt 1
        rst = 1; tick(); rst = 0; #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b want 0", stall); end
        n_cmp++; if (stall_cnt !== 0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
        n_cmp++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            n_fail++; $display("FAIL rst_sel: got a=%0d b=%0d want 0/0", fwd_a_sel, fwd_b_sel); end
    endtask

    task automatic test_saturation();
        reset_dut();
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            drive(1, 9, 1, 8, 0, 8, 1, 1, 0); tick();
            drive(1, 8, 1, 3, 1, 10, 1, 0, 0); tick(); tick();
        end
        #1;
        n_cmp++; if (stall_cnt !== CNT_MAX) begin n_fail++; $display("FAIL sat_cnt: got %0d want %0d", stall_cnt, CNT_MAX); end
        n_cmp++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL sat_model: got %0d want %0d", stall_cnt, exp_cnt); end
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            if (!ref_stall()) begin
                drive($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                      $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
            end
            rst = ($urandom_range(0, 49) == 0);
            #1;
            n_cmp++; if (stall !== ref_stall()) begin
                n_fail++; $display("FAIL rnd_stall cyc %0d: got %0b want %0b", i, stall, ref_stall()); end
            tick(); #1;
            n_cmp++; if (fwd_a_sel !== exp_a) begin n_fail++; $display("FAIL rnd_a cyc %0d: got %0d want %0d", i, fwd_a_sel, exp_a); end
            n_cmp++; if (fwd_b_sel !== exp_b) begin n_fail++; $display("FAIL rnd_b cyc %0d: got %0d want %0d", i, fwd_b_sel, exp_b); end
            n_cmp++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL rnd_cnt cyc %0d: got %0d want %0d", i, stall_cnt, exp_cnt); end
        end
        rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; nop(); model_reset();
        @(negedge clk);
        test_reset();
        test_exmem_fwd();
        test_memwb_fwd();
        test_load_use();
        test_zero_reg();
        test_flush_hazard();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
